// File: rtl/bnw_lane_pkg.sv
// Shared lane constants for every falling-block lane of the rhythm game.
// Each lane instance takes its defaults from here so all lanes agree on
// spawn height, retire height, fall speed and the hit window.
package bnw_lane_pkg;

    localparam int LANE_DEPTH    = 4;
    localparam int LANE_H_W      = 10;
    localparam int LANE_BEAT_W   = 7;
    localparam int LANE_SPAWN_H  = 120;
    localparam int LANE_BOTTOM_H = 720;
    localparam int LANE_SPEED    = 1;
    localparam int LANE_HIT_LO   = 600;
    localparam int LANE_HIT_HI   = 719;

    // True when a height lies inside the inclusive hit window.
    function automatic logic in_hit_window(input int h, input int lo, input int hi);
        return (h >= lo) && (h <= hi);
    endfunction

endpackage

// File: rtl/lane_slot.sv
// One block slot of a lane: holds an occupied flag and a height.
// Priority of the per-slot commands: clear > kill > spawn > step.
// A killed slot is freed without signalling a retire, so a block hit in
// the same cycle it would have fallen off the bottom is not a miss.
module lane_slot
    import bnw_lane_pkg::*;
#(
    parameter int H_W      = LANE_H_W,
    parameter int SPAWN_H  = LANE_SPAWN_H,
    parameter int BOTTOM_H = LANE_BOTTOM_H,
    parameter int SPEED    = LANE_SPEED
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           spawn,
    input  logic           step,
    input  logic           kill,
    output logic           vld,
    output logic [H_W-1:0] h,
    output logic           retire
);

    logic           vld_q, vld_d;
    logic [H_W-1:0] h_q, h_d;
    logic [H_W:0]   h_sum;

    // Next-state for the slot; the step sum carries one extra bit so an
    // overshoot past the bottom cannot wrap back into the playfield.
    always_comb begin
        h_sum  = {1'b0, h_q} + (H_W+1)'(SPEED);
        vld_d  = vld_q;
        h_d    = h_q;
        retire = 1'b0;
        if (clear) begin
            vld_d = 1'b0;
            h_d   = H_W'(BOTTOM_H);
        end else if (kill && vld_q) begin
            vld_d = 1'b0;
            h_d   = H_W'(BOTTOM_H);
        end else if (spawn && !vld_q) begin
            vld_d = 1'b1;
            h_d   = H_W'(SPAWN_H);
        end else if (step && vld_q) begin
            if (h_sum >= (H_W+1)'(BOTTOM_H)) begin
                vld_d  = 1'b0;
                h_d    = H_W'(BOTTOM_H);
                retire = 1'b1;
            end else begin
                h_d = h_sum[H_W-1:0];
            end
        end
    end

    // Slot state flops; empty slots park at the bottom height.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            h_q   <= H_W'(BOTTOM_H);
        end else begin
            vld_q <= vld_d;
            h_q   <= h_d;
        end
    end

    assign vld = vld_q;
    assign h   = h_q;

endmodule

// File: rtl/lane_block_gen.sv
// Falling-block lane generator. Spawns blocks on mapped song beats,
// moves them down on each tick, retires them at the bottom (miss) and
// resolves player strikes against the lowest-on-screen block.
module lane_block_gen
    import bnw_lane_pkg::*;
#(
    parameter int DEPTH    = LANE_DEPTH,
    parameter int H_W      = LANE_H_W,
    parameter int BEAT_W   = LANE_BEAT_W,
    parameter int SPAWN_H  = LANE_SPAWN_H,
    parameter int BOTTOM_H = LANE_BOTTOM_H,
    parameter int SPEED    = LANE_SPEED,
    parameter int HIT_LO   = LANE_HIT_LO,
    parameter int HIT_HI   = LANE_HIT_HI
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   restart,
    input  logic                   pause,
    input  logic                   tick,
    input  logic [BEAT_W-1:0]      beat_cnt,
    input  logic [2**BEAT_W-1:0]   spawn_map,
    input  logic                   hit,
    output logic [DEPTH*H_W-1:0]   block_h,
    output logic [DEPTH-1:0]       block_vld,
    output logic                   hit_ok,
    output logic                   hit_bad,
    output logic                   miss,
    output logic                   overflow
);

    logic [BEAT_W-1:0] prev_beat_q, prev_beat_d;
    logic              hit_ok_q, hit_ok_d;
    logic              hit_bad_q, hit_bad_d;
    logic              miss_q, miss_d;
    logic              overflow_q, overflow_d;

    logic [DEPTH-1:0]  slot_vld;
    logic [DEPTH-1:0]  slot_retire;
    logic [H_W-1:0]    slot_h [DEPTH];
    logic [DEPTH-1:0]  spawn_vec;
    logic [DEPTH-1:0]  kill_vec;
    logic [DEPTH-1:0]  tgt_vec;
    logic [H_W-1:0]    best_h;
    logic              tgt_found;
    logic              spawn_taken;
    logic              tgt_in_win;

    logic beat_add;
    logic spawn_req;
    logic step;

    // A beat is "added" only on an upward move of the counter, so a wrap
    // to zero or a held value never re-triggers a spawn.
    assign beat_add  = beat_cnt > prev_beat_q;
    assign spawn_req = beat_add & spawn_map[beat_cnt] & ~pause;
    assign step      = tick & ~pause;

    // Spawn arbitration: lowest slot that is empty at the start of the cycle.
    always_comb begin
        spawn_vec   = '0;
        spawn_taken = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!slot_vld[i] && !spawn_taken) begin
                spawn_vec[i] = spawn_req;
                spawn_taken  = 1'b1;
            end
        end
    end

    // Hit target: occupied slot with the largest pre-motion height,
    // lowest index winning ties (strict compare keeps the first found).
    always_comb begin
        tgt_vec   = '0;
        best_h    = '0;
        tgt_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_vld[i] && (!tgt_found || slot_h[i] > best_h)) begin
                tgt_vec    = '0;
                tgt_vec[i] = 1'b1;
                best_h     = slot_h[i];
                tgt_found  = 1'b1;
            end
        end
        tgt_in_win = tgt_found && in_hit_window(int'(best_h), HIT_LO, HIT_HI);
        kill_vec   = (hit && tgt_in_win) ? tgt_vec : '0;
    end

    // Event pulses and beat history; restart suppresses every pulse.
    always_comb begin
        prev_beat_d = restart ? '0 : beat_cnt;
        hit_ok_d    = ~restart & hit & tgt_in_win;
        hit_bad_d   = ~restart & hit & ~tgt_in_win;
        miss_d      = ~restart & (|slot_retire);
        overflow_d  = ~restart & spawn_req & (&slot_vld);
    end

    // Registered event outputs and previous-beat capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_beat_q <= '0;
            hit_ok_q    <= 1'b0;
            hit_bad_q   <= 1'b0;
            miss_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            prev_beat_q <= prev_beat_d;
            hit_ok_q    <= hit_ok_d;
            hit_bad_q   <= hit_bad_d;
            miss_q      <= miss_d;
            overflow_q  <= overflow_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            lane_slot #(
                .H_W      (H_W),
                .SPAWN_H  (SPAWN_H),
                .BOTTOM_H (BOTTOM_H),
                .SPEED    (SPEED)
            ) u_slot (
                .clk    (clk),
                .rst_n  (rst_n),
                .clear  (restart),
                .spawn  (spawn_vec[gi]),
                .step   (step),
                .kill   (kill_vec[gi]),
                .vld    (slot_vld[gi]),
                .h      (slot_h[gi]),
                .retire (slot_retire[gi])
            );
            assign block_h[gi*H_W +: H_W] = slot_h[gi];
        end
    endgenerate

    assign block_vld = slot_vld;
    assign hit_ok    = hit_ok_q;
    assign hit_bad   = hit_bad_q;
    assign miss      = miss_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_lane_block_gen.sv
// Bench for lane_block_gen: directed scenarios plus a randomized run, all
// checked cycle by cycle against a behavioural lane model.
module tb_lane_block_gen;

    localparam int DEPTH    = 4;
    localparam int H_W      = 10;
    localparam int BEAT_W   = 7;
    localparam int SPAWN_H  = 120;
    localparam int BOTTOM_H = 720;
    localparam int SPEED    = 1;
    localparam int HIT_LO   = 600;
    localparam int HIT_HI   = 719;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 restart = 1'b0;
    logic                 pause = 1'b0;
    logic                 tick = 1'b0;
    logic                 hit = 1'b0;
    logic [BEAT_W-1:0]    beat_cnt = '0;
    logic [2**BEAT_W-1:0] spawn_map = '0;
    logic [DEPTH*H_W-1:0] block_h;
    logic [DEPTH-1:0]     block_vld;
    logic                 hit_ok, hit_bad, miss, overflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit verbose  = 1'b1;

    // Model state: heights, occupancy, last beat seen, expected pulses.
    int mh [DEPTH];
    bit mv [DEPTH];
    int mprev;
    bit e_ok, e_bad, e_miss, e_ovf;

    always #5 clk = ~clk;

    lane_block_gen #(
        .DEPTH(DEPTH), .H_W(H_W), .BEAT_W(BEAT_W), .SPAWN_H(SPAWN_H),
        .BOTTOM_H(BOTTOM_H), .SPEED(SPEED), .HIT_LO(HIT_LO), .HIT_HI(HIT_HI)
    ) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart), .pause(pause),
        .tick(tick), .beat_cnt(beat_cnt), .spawn_map(spawn_map), .hit(hit),
        .block_h(block_h), .block_vld(block_vld), .hit_ok(hit_ok),
        .hit_bad(hit_bad), .miss(miss), .overflow(overflow)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            mh[i] = BOTTOM_H;
            mv[i] = 1'b0;
        end
        mprev = 0;
        e_ok = 0; e_bad = 0; e_miss = 0; e_ovf = 0;
    endfunction

    // One clock of lane behaviour, derived from the game rules.
    function automatic void model_update();
        int  nh [DEPTH];
        bit  nv [DEPTH];
        int  tgt;
        bit  spawn;
        bit  placed;
        e_ok = 0; e_bad = 0; e_miss = 0; e_ovf = 0;
        if (restart) begin
            model_clear();
            return;
        end
        spawn = (int'(beat_cnt) > mprev) && spawn_map[beat_cnt] && !pause;
        mprev = int'(beat_cnt);
        nh = mh;
        nv = mv;
        if (hit) begin
            tgt = -1;
            for (int i = 0; i < DEPTH; i++)
                if (mv[i] && (tgt < 0 || mh[i] > mh[tgt])) tgt = i;
            if (tgt >= 0 && mh[tgt] >= HIT_LO && mh[tgt] <= HIT_HI) begin
                e_ok = 1;
                nv[tgt] = 0;
                nh[tgt] = BOTTOM_H;
            end else begin
                e_bad = 1;
            end
        end
        if (tick && !pause) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mv[i] && nv[i]) begin
                    if (mh[i] + SPEED >= BOTTOM_H) begin
                        nv[i] = 0;
                        nh[i] = BOTTOM_H;
                        e_miss = 1;
                    end else begin
                        nh[i] = mh[i] + SPEED;
                    end
                end
            end
        end
        if (spawn) begin
            placed = 0;
            for (int i = 0; i < DEPTH; i++) begin
                if (!placed && !mv[i]) begin
                    nv[i] = 1;
                    nh[i] = SPAWN_H;
                    placed = 1;
                end
            end
            if (!placed) e_ovf = 1;
        end
        mh = nh;
        mv = nv;
    endfunction

    task automatic compare_all(input string tag);
        logic [DEPTH*H_W-1:0] exp_h;
        logic [DEPTH-1:0]     exp_v;
        for (int i = 0; i < DEPTH; i++) begin
            exp_h[i*H_W +: H_W] = H_W'(mh[i]);
            exp_v[i] = mv[i];
        end
        check_eq({tag, ".block_h"},   64'(block_h),   64'(exp_h));
        check_eq({tag, ".block_vld"}, 64'(block_vld), 64'(exp_v));
        check_eq({tag, ".hit_ok"},    64'(hit_ok),    64'(e_ok));
        check_eq({tag, ".hit_bad"},   64'(hit_bad),   64'(e_bad));
        check_eq({tag, ".miss"},      64'(miss),      64'(e_miss));
        check_eq({tag, ".overflow"},  64'(overflow),  64'(e_ovf));
    endtask

    // Apply the current inputs for one clock, then compare against the model.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_update();
        #1;
        compare_all(tag);
        if (verbose && (hit || restart || e_ovf || e_miss || (block_vld != 0 && tick == 0)))
            $display("txn %s beat=%0d hit=%0d restart=%0d vld=%b ok=%0d bad=%0d miss=%0d ovf=%0d",
                     tag, beat_cnt, hit, restart, block_vld, hit_ok, hit_bad, miss, overflow);
    endtask

    task automatic drive(input string tag, input bit t, input bit h, input bit p,
                         input int b, input bit r);
        tick = t; hit = h; pause = p; beat_cnt = BEAT_W'(b); restart = r;
        cycle(tag);
        tick = 0; hit = 0; pause = 0; restart = 0;
    endtask

    task automatic run_ticks(input string tag, input int n, input int b, input bit p);
        for (int k = 0; k < n; k++) drive(tag, 1'b1, 1'b0, p, b, 1'b0);
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        rst_n = 1'b1;

        // First mapped beat spawns into slot 0; unmapped beats do nothing.
        spawn_map = '0;
        spawn_map[1] = 1'b1;
        drive("spawn_first", 0, 0, 0, 1, 0);
        check_eq("spawn_first.slot0_h", 64'(block_h[H_W-1:0]), 64'(SPAWN_H));
        drive("spawn_hold", 0, 0, 0, 1, 0);
        drive("unmapped2", 0, 0, 0, 2, 0);
        drive("unmapped3", 0, 0, 0, 3, 0);
        check_eq("unmapped.vld", 64'(block_vld), 64'h1);

        // Full fall to the bottom.
        verbose = 0;
        run_ticks("fall", 599, 3, 0);
        check_eq("fall.h719", 64'(block_h[H_W-1:0]), 64'(719));
        verbose = 1;
        drive("fall_last", 1, 0, 0, 3, 0);
        check_eq("fall_last.miss", 64'(miss), 64'h1);

        // Five consecutive mapped beats into four slots.
        drive("restart_a", 0, 0, 0, 0, 1);
        spawn_map = '1;
        for (int b = 1; b <= 5; b++) drive("fill", 0, 0, 0, b, 0);
        check_eq("fill.ovf", 64'(overflow), 64'h1);
        check_eq("fill.vld", 64'(block_vld), 64'hF);

        // Blocks at 650 and 300: first hit frees 650, second misses the window.
        drive("restart_b", 0, 0, 0, 0, 1);
        drive("spawnA", 0, 0, 0, 1, 0);
        verbose = 0;
        run_ticks("moveA", 350, 1, 0);
        verbose = 1;
        drive("spawnB", 0, 0, 0, 2, 0);
        verbose = 0;
        run_ticks("moveAB", 180, 2, 0);
        verbose = 1;
        drive("hit650", 0, 1, 0, 2, 0);
        check_eq("hit650.ok", 64'(hit_ok), 64'h1);
        drive("hit300", 0, 1, 0, 2, 0);
        check_eq("hit300.bad", 64'(hit_bad), 64'h1);
        check_eq("hit300.vld", 64'(block_vld), 64'h2);

        // Block at 719 hit on the same cycle as its final tick.
        drive("restart_c", 0, 0, 0, 0, 1);
        drive("spawnC", 0, 0, 0, 1, 0);
        verbose = 0;
        run_ticks("moveC", 599, 1, 0);
        verbose = 1;
        drive("hit719", 1, 1, 0, 1, 0);
        check_eq("hit719.ok", 64'(hit_ok), 64'h1);
        check_eq("hit719.miss", 64'(miss), 64'h0);

        // Pause freezes motion and blocks spawning.
        drive("spawnD", 0, 0, 0, 2, 0);
        verbose = 0;
        run_ticks("paused", 50, 2, 1);
        verbose = 1;
        check_eq("paused.h", 64'(block_h[H_W-1:0]), 64'(SPAWN_H));
        drive("paused_beat", 1, 0, 1, 3, 0);
        check_eq("paused_beat.vld", 64'(block_vld), 64'h1);

        // Restart beats a spawn beat, a hit and a tick in the same cycle.
        drive("restart_d", 0, 0, 0, 0, 1);
        for (int b = 1; b <= 3; b++) begin
            drive("spawnE", 0, 0, 0, b, 0);
            verbose = 0;
            run_ticks("moveE", 20, b, 0);
            verbose = 1;
        end
        drive("restart_all", 1, 1, 0, 4, 1);
        check_eq("restart_all.vld", 64'(block_vld), 64'h0);

        // Asynchronous reset mid-run, released before the next edge.
        drive("spawnF", 0, 0, 0, 1, 0);
        rst_n = 1'b0;
        #1;
        model_clear();
        compare_all("async_rst");
        #1;
        rst_n = 1'b1;

        // Randomized play.
        verbose = 0;
        for (int k = 0; k < 6000; k++) begin
            tick    = ($urandom_range(0, 1) == 1);
            hit     = ($urandom_range(0, 7) == 0);
            pause   = ($urandom_range(0, 9) == 0);
            restart = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 199) == 0)
                beat_cnt = BEAT_W'($urandom);
            else if ($urandom_range(0, 5) == 0)
                beat_cnt = beat_cnt + 1'b1;
            if ($urandom_range(0, 63) == 0)
                spawn_map = {$urandom, $urandom, $urandom, $urandom};
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
